multicycle_controller: RTL and testbench

Multi-cycle control FSM that sequences the single-cycle MIPS-subset datapath over several clocks per instruction. It decodes opcode/funct, drives every datapath control input, and commits the PC exactly once per instruction. It stalls on a data-memory ready handshake and halts on illegal opcodes. It also keeps a retired-instruction counter for bring-up and verification.

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/multicycle_controller_if.sv | 30 +++
 rtl/ctrl_decode.sv | 45 ++++
 rtl/multicycle_controller.sv | 94 +++++++++
 tb/tb_multicycle_controller.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode/funct and ALU op encodings for the MIPS-subset control path
package mips_ctrl_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE
  } instr_class_t;

  typedef struct packed {
    logic       reg_dest;
    logic       alu_src;
    logic       alu_src2;
    logic       reg_sel;
    logic       mem_to_reg;
    logic [3:0] operation;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - datapath-facing control bus between controller and datapath
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic       RegDest;
  logic       RegisterWrite;
  logic       ALUSource;
  logic       ALUSource2;
  logic       RegSel;
  logic       WriteMem;
  logic       ReadMem;
  logic       MemToReg;
  logic       PCSource;
  logic [3:0] operation;
  logic       pc_write;

  modport master (
    output opcode, funct, Zero, mem_ready,
    input  RegDest, RegisterWrite, ALUSource, ALUSource2, RegSel,
    input  WriteMem, ReadMem, MemToReg, PCSource, operation, pc_write
  );

  modport slave (
    input  opcode, funct, Zero, mem_ready,
    output RegDest, RegisterWrite, ALUSource, ALUSource2, RegSel,
    output WriteMem, ReadMem, MemToReg, PCSource, operation, pc_write
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational decode of latched opcode/funct into class, legality and static controls
import mips_ctrl_pkg::*;

module ctrl_decode (
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         legal,
  output ctrl_word_t   cw
);

  always_comb begin
    cls   = CLS_RTYPE;
    legal = 1'b0;
    cw    = '0;
    case (opcode)
      OP_RTYPE: begin
        cls         = CLS_RTYPE;
        legal       = 1'b1;
        cw.reg_dest = 1'b1;
        case (funct)
          FN_ADD: cw.operation = ALU_ADD;
          FN_SUB: cw.operation = ALU_SUB;
          FN_AND: cw.operation = ALU_AND;
          FN_OR:  cw.operation = ALU_OR;
          FN_SLT: cw.operation = ALU_SLT;
          // shifts take shamt as B and rt as A
          FN_SLL: begin cw.operation = ALU_SLL; cw.alu_src2 = 1'b1; cw.reg_sel = 1'b1; end
          FN_SRL: begin cw.operation = ALU_SRL; cw.alu_src2 = 1'b1; cw.reg_sel = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin cls = CLS_ADDI; legal = 1'b1; cw.alu_src = 1'b1; cw.operation = ALU_ADD; end
      OP_LW: begin
        cls = CLS_LW; legal = 1'b1;
        cw.alu_src = 1'b1; cw.mem_to_reg = 1'b1; cw.operation = ALU_ADD;
      end
      OP_SW:  begin cls = CLS_SW;  legal = 1'b1; cw.alu_src = 1'b1; cw.operation = ALU_ADD; end
      OP_BEQ: begin cls = CLS_BEQ; legal = 1'b1; cw.operation = ALU_SUB; end
      OP_BNE: begin cls = CLS_BNE; legal = 1'b1; cw.operation = ALU_SUB; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FSM sequencing the MIPS-subset datapath, with retired counter
import mips_ctrl_pkg::*;

module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.slave  bus,
  output logic                    halted,
  output logic [2:0]              state,
  output logic [31:0]             retired
);

  logic [5:0]   ir_op;
  logic [5:0]   ir_funct;
  logic [2:0]   next_state;
  instr_class_t cls;
  logic         legal;
  ctrl_word_t   cw;
  logic         active;
  logic         is_branch;
  logic         taken;
  logic         commit;

  ctrl_decode u_decode (
    .opcode (ir_op),
    .funct  (ir_funct),
    .cls    (cls),
    .legal  (legal),
    .cw     (cw)
  );

  assign is_branch = (cls == CLS_BEQ) || (cls == CLS_BNE);
  assign taken     = ((cls == CLS_BEQ) && bus.Zero) || ((cls == CLS_BNE) && !bus.Zero);
  assign commit    = ((state == S_EXEC) && is_branch) ||
                     ((state == S_MEM) && (cls == CLS_SW) && bus.mem_ready) ||
                     (state == S_WB);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_branch)
          next_state = S_FETCH;
        else if ((cls == CLS_LW) || (cls == CLS_SW))
          next_state = S_MEM;
        else
          next_state = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready)
          next_state = (cls == CLS_LW) ? S_WB : S_FETCH;
      end
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      ir_op    <= '0;
      ir_funct <= '0;
      retired  <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        ir_op    <= bus.opcode;
        ir_funct <= bus.funct;
      end
      if (commit)
        retired <= retired + 32'd1;
    end
  end

  // static controls are held from EXEC through the commit cycle
  assign active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  assign bus.RegDest       = active && cw.reg_dest;
  assign bus.ALUSource     = active && cw.alu_src;
  assign bus.ALUSource2    = active && cw.alu_src2;
  assign bus.RegSel        = active && cw.reg_sel;
  assign bus.MemToReg      = active && cw.mem_to_reg;
  assign bus.operation     = active ? cw.operation : 4'b0000;
  assign bus.RegisterWrite = (state == S_WB);
  assign bus.ReadMem       = (state == S_MEM) && (cls == CLS_LW);
  assign bus.WriteMem      = (state == S_MEM) && (cls == CLS_SW);
  assign bus.pc_write      = commit;
  assign bus.PCSource      = (state == S_EXEC) && is_branch && taken;
  assign halted            = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] retired;
  int          checks;
  int          errors;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .halted  (halted),
    .state   (state),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_pc_write", bus.pc_write, 0);
    check("rst_operation", bus.operation, 0);

    // add
    rst = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
    check("add_fetch_state", state, 0);
    step(); check("add_decode_state", state, 1);
    check("add_decode_rw", bus.RegisterWrite, 0);
    step(); check("add_exec_state", state, 2);
    check("add_exec_regdest", bus.RegDest, 1);
    check("add_exec_op", bus.operation, 4'b0010);
    check("add_exec_rw", bus.RegisterWrite, 0);
    check("add_exec_pcw", bus.pc_write, 0);
    step(); check("add_wb_state", state, 4);
    check("add_wb_rw", bus.RegisterWrite, 1);
    check("add_wb_pcw", bus.pc_write, 1);
    check("add_wb_pcsrc", bus.PCSource, 0);
    step(); check("add_retired", retired, 1);
    check("add_next_state", state, 0);

    // lw with two wait cycles
    bus.opcode = 6'h23; bus.funct = 6'h00;
    step(); step();
    check("lw_exec_alusrc", bus.ALUSource, 1);
    check("lw_exec_op", bus.operation, 4'b0010);
    check("lw_exec_rm", bus.ReadMem, 0);
    step(); check("lw_mem1_rm", bus.ReadMem, 1);
    check("lw_mem1_pcw", bus.pc_write, 0);
    step(); check("lw_mem2_rm", bus.ReadMem, 1);
    check("lw_mem2_state", state, 3);
    step(); check("lw_mem3_rm", bus.ReadMem, 1);
    bus.mem_ready = 1'b1;
    check("lw_mem3_pcw", bus.pc_write, 0);
    step(); check("lw_wb_state", state, 4);
    check("lw_wb_m2r", bus.MemToReg, 1);
    check("lw_wb_rw", bus.RegisterWrite, 1);
    check("lw_wb_pcw", bus.pc_write, 1);
    check("lw_wb_pcsrc", bus.PCSource, 0);
    check("lw_wb_rm", bus.ReadMem, 0);
    bus.mem_ready = 1'b0;
    step(); check("lw_retired", retired, 2);

    // beq taken
    bus.opcode = 6'h04; bus.Zero = 1'b1;
    step(); step();
    check("beq_state", state, 2);
    check("beq_pcw", bus.pc_write, 1);
    check("beq_pcsrc", bus.PCSource, 1);
    check("beq_op", bus.operation, 4'b0110);
    step(); check("beq_retired", retired, 3);
    check("beq_next_state", state, 0);

    // bne not taken
    bus.opcode = 6'h05;
    step(); step();
    check("bne_pcw", bus.pc_write, 1);
    check("bne_pcsrc", bus.PCSource, 0);
    step(); check("bne_retired", retired, 4);
    bus.Zero = 1'b0;

    // sw, no wait; mem_ready high early must be ignored
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    step(); step();
    check("sw_exec_state", state, 2);
    check("sw_exec_pcw", bus.pc_write, 0);
    step(); check("sw_mem_wm", bus.WriteMem, 1);
    check("sw_mem_rm", bus.ReadMem, 0);
    check("sw_mem_pcw", bus.pc_write, 1);
    check("sw_mem_rw", bus.RegisterWrite, 0);
    step(); check("sw_state", state, 0);
    check("sw_retired", retired, 5);
    bus.mem_ready = 1'b0;

    // sll
    bus.opcode = 6'h00; bus.funct = 6'h00;
    step(); step();
    check("sll_exec_src2", bus.ALUSource2, 1);
    check("sll_exec_regsel", bus.RegSel, 1);
    check("sll_exec_op", bus.operation, 4'b1000);
    step(); check("sll_wb_src2", bus.ALUSource2, 1);
    check("sll_wb_regsel", bus.RegSel, 1);
    check("sll_wb_op", bus.operation, 4'b1000);
    step(); check("sll_retired", retired, 6);

    // illegal opcode
    bus.opcode = 6'h3F;
    step(); check("ill_decode_state", state, 1);
    step(); check("ill_halt_state", state, 5);
    check("ill_halted", halted, 1);
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1; bus.Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_state", state, 5);
      check("halt_pcw", bus.pc_write, 0);
      check("halt_rw", bus.RegisterWrite, 0);
      check("halt_wm", bus.WriteMem, 0);
      check("halt_retired", retired, 6);
    end

    rst = 1'b0;
    step(); check("unhalt_state", state, 0);
    check("unhalt_halted", halted, 0);
    check("unhalt_retired", retired, 0);

    // reset during sw stall
    rst = 1'b1; bus.opcode = 6'h2B; bus.mem_ready = 1'b0; bus.Zero = 1'b0;
    step(); step();
    check("sw2_exec_wm", bus.WriteMem, 0);
    step(); check("sw2_mem_wm", bus.WriteMem, 1);
    check("sw2_mem_pcw", bus.pc_write, 0);
    step(); check("sw2_stall_wm", bus.WriteMem, 1);
    rst = 1'b0;
    step(); check("midrst_state", state, 0);
    check("midrst_wm", bus.WriteMem, 0);
    check("midrst_retired", retired, 0);
    check("midrst_halted", halted, 0);
    check("midrst_pcw", bus.pc_write, 0);

    rst = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
    step(); step();
    check("add2_exec_op", bus.operation, 4'b0010);
    step(); check("add2_wb_pcw", bus.pc_write, 1);
    step(); check("add2_retired", retired, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
